// File: rtl/rom_load_sequencer.sv
// ROM download sequencer: forwards HPS ioctl writes to the core ROM port
// with a region tag, validates the image size, and owns the game-core reset
// (held until a good image has loaded, stretched after user reset requests).
module rom_load_sequencer #(
  parameter logic [16:0] ROM_SIZE    = 17'h14000,
  parameter logic [16:0] CPU_END     = 17'h0C000,
  parameter logic [16:0] GFX_END     = 17'h13000,
  parameter int          HOLD_CYCLES = 1024
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        rst_req,
  output logic [16:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic [1:0]  dn_region,
  output logic        core_reset,
  output logic        load_ok,
  output logic        load_err
);

  typedef enum logic [2:0] {BOOT, LOAD, HOLD, RUN, URST} state_t;

  localparam int              HOLD_W     = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [24:0]     ROM_SIZE_W = {8'd0, ROM_SIZE};

  state_t            state;
  logic              dl_q;
  logic [24:0]       wr_cnt;
  logic              ovf;
  logic [HOLD_W-1:0] hold_cnt;

  logic dl_rise;
  logic dl_fall;
  logic in_range;
  logic accept;

  assign dl_rise  = ioctl_download & ~dl_q;
  assign dl_fall  = ~ioctl_download & dl_q;
  assign in_range = (ioctl_addr < ROM_SIZE_W);
  // A write only counts while the FSM is already in LOAD and the download is still active.
  assign accept   = (state == LOAD) && ioctl_download && ioctl_wr;

  // Delayed copy of the download flag for edge detection.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) dl_q <= 1'b0;
    else          dl_q <= ioctl_download;
  end

  // Forward accepted in-range writes to the ROM port one cycle later, tagged with their region.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dn_wr     <= 1'b0;
      dn_addr   <= '0;
      dn_data   <= '0;
      dn_region <= 2'd0;
    end else if (accept && in_range) begin
      dn_wr   <= 1'b1;
      dn_addr <= ioctl_addr[16:0];
      dn_data <= ioctl_dout;
      if (ioctl_addr[16:0] < CPU_END)      dn_region <= 2'd0;
      else if (ioctl_addr[16:0] < GFX_END) dn_region <= 2'd1;
      else                                 dn_region <= 2'd2;
    end else begin
      dn_wr <= 1'b0;
    end
  end

  // Load/reset FSM: core_reset is registered alongside the state so it follows the state it enters.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= BOOT;
      wr_cnt     <= '0;
      ovf        <= 1'b0;
      hold_cnt   <= '0;
      core_reset <= 1'b1;
      load_ok    <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          if (dl_rise) begin
            state      <= LOAD;
            wr_cnt     <= '0;
            ovf        <= 1'b0;
            core_reset <= 1'b1;
          end
        end

        LOAD: begin
          if (dl_fall) begin
            if (wr_cnt == ROM_SIZE_W && !ovf) begin
              load_ok  <= 1'b1;
              load_err <= 1'b0;
              state    <= HOLD;
              hold_cnt <= '0;
            end else begin
              load_ok  <= 1'b0;
              load_err <= 1'b1;
              state    <= BOOT;
            end
            core_reset <= 1'b1;
          end else if (accept) begin
            if (wr_cnt != '1) wr_cnt <= wr_cnt + 25'd1;
            if (!in_range)    ovf    <= 1'b1;
          end
        end

        HOLD: begin
          if (dl_rise) begin
            state      <= LOAD;
            wr_cnt     <= '0;
            ovf        <= 1'b0;
            core_reset <= 1'b1;
          end else if (rst_req) begin
            state      <= URST;
            core_reset <= 1'b1;
          end else if (hold_cnt == HOLD_LAST) begin
            state      <= RUN;
            core_reset <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        RUN: begin
          if (dl_rise) begin
            state      <= LOAD;
            wr_cnt     <= '0;
            ovf        <= 1'b0;
            core_reset <= 1'b1;
          end else if (rst_req) begin
            state      <= URST;
            core_reset <= 1'b1;
          end
        end

        URST: begin
          if (dl_rise) begin
            state      <= LOAD;
            wr_cnt     <= '0;
            ovf        <= 1'b0;
            core_reset <= 1'b1;
          end else if (!rst_req) begin
            state      <= HOLD;
            hold_cnt   <= '0;
            core_reset <= 1'b1;
          end
        end

        default: begin
          state      <= BOOT;
          core_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Self-checking bench for rom_load_sequencer with a small ROM map
// (16 bytes: CPU 0..7, GFX 8..11, PROM 12..15, 8-cycle core-reset hold).
module tb_rom_load_sequencer;

  localparam int ROM  = 16;
  localparam int CPU  = 8;
  localparam int GFX  = 12;
  localparam int HOLD = 8;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        rst_req = 1'b0;
  logic [16:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic [1:0]  dn_region;
  logic        core_reset;
  logic        load_ok;
  logic        load_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int cyc;
    int addr;
    int data;
    int region;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];
  int  m_cnt;
  bit  m_ovf;

  rom_load_sequencer #(
    .ROM_SIZE   (17'd16),
    .CPU_END    (17'd8),
    .GFX_END    (17'd12),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .rst_req       (rst_req),
    .dn_addr       (dn_addr),
    .dn_data       (dn_data),
    .dn_wr         (dn_wr),
    .dn_region     (dn_region),
    .core_reset    (core_reset),
    .load_ok       (load_ok),
    .load_err      (load_err)
  );

  // 100 MHz system clock.
  always #5 clk_sys = ~clk_sys;

  // Cycle counter used to timestamp writes and ROM-port pulses.
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Record every ROM-port write pulse seen mid-cycle.
  always @(negedge clk_sys) begin
    wr_t e;
    if (dn_wr === 1'b1) begin
      e.cyc = cyc;
      e.addr = int'(dn_addr);
      e.data = int'(dn_data);
      e.region = int'(dn_region);
      obs_q.push_back(e);
    end
  end

  // Safety net so the run always terminates.
  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic int region_of(input int a);
    if (a < CPU) return 0;
    if (a < GFX) return 1;
    return 2;
  endfunction

  function automatic bit pulses_match();
    if (obs_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) begin
      if (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].addr != exp_q[i].addr ||
          obs_q[i].data != exp_q[i].data || obs_q[i].region != exp_q[i].region)
        return 1'b0;
    end
    return 1'b1;
  endfunction

  // Raise the download flag, optionally with a write in the same cycle (expected dropped).
  task automatic start_dl(input bit wr_on_rise);
    exp_q.delete();
    obs_q.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    ioctl_download = 1'b1;
    if (wr_on_rise) begin
      ioctl_wr = 1'b1;
      ioctl_addr = 25'd0;
      ioctl_dout = 8'h5A;
    end
    tick();
    ioctl_wr = 1'b0;
  endtask

  // One write strobe followed by a random idle gap; the model records what should come out.
  task automatic send_write(input int a, input logic [7:0] d);
    wr_t e;
    ioctl_wr = 1'b1;
    ioctl_addr = 25'(a);
    ioctl_dout = d;
    m_cnt++;
    if (a < ROM) begin
      e.cyc = cyc + 1;
      e.addr = a;
      e.data = int'(d);
      e.region = region_of(a);
      exp_q.push_back(e);
    end else begin
      m_ovf = 1'b1;
    end
    tick();
    ioctl_wr = 1'b0;
    repeat ($urandom_range(0, 2)) tick();
  endtask

  // Drop the download flag, optionally with a write in the same cycle (expected dropped).
  task automatic end_dl(input bit wr_on_fall);
    ioctl_download = 1'b0;
    if (wr_on_fall) begin
      ioctl_wr = 1'b1;
      ioctl_addr = 25'd1;
      ioctl_dout = 8'hC3;
    end
    tick();
    ioctl_wr = 1'b0;
  endtask

  // Edges from the download drop until core_reset reads 0 (capped at 40).
  task automatic edges_to_release(output int n);
    n = 1;
    while (core_reset !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    logic [30:0] rst_vec;
    #2 reset_n = 1'b0;
    #1;
    rst_vec = {dn_addr, dn_data, dn_wr, dn_region, core_reset, load_ok, load_err};
    checks++;
    if (rst_vec !== {17'd0, 8'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_values: got %h expected %h", rst_vec,
               {17'd0, 8'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0});
    end
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_boot_idle();
    int bad = 0;
    obs_q.delete();
    for (int i = 0; i < 1000; i++) begin
      rst_req = 1'($urandom_range(0, 1));
      ioctl_wr = 1'($urandom_range(0, 1));
      ioctl_addr = 25'($urandom_range(0, 20));
      ioctl_dout = 8'($urandom);
      tick();
      if (core_reset !== 1'b1) bad++;
    end
    rst_req = 1'b0;
    ioctl_wr = 1'b0;
    tick();
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL boot_core_reset: %0d cycles with core_reset low, required 0", bad);
    end
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL boot_no_dn_wr: %0d dn_wr pulses, required 0", obs_q.size());
    end
    checks++;
    if ({load_ok, load_err} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL boot_flags: ok/err=%b required 00", {load_ok, load_err});
    end
  endtask

  task automatic test_good_load();
    int n;
    start_dl(1'b0);
    for (int a = 0; a < ROM; a++) send_write(a, 8'(a) ^ 8'hA5);
    end_dl(1'b0);
    checks++;
    if (!pulses_match()) begin
      failures++;
      $display("[TB] FAIL good_load_pulses: %0d pulses observed, %0d required with exact addr/data/region/cycle",
               obs_q.size(), exp_q.size());
    end
    checks++;
    if ({load_ok, load_err} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL good_load_flags: ok/err=%b required 10", {load_ok, load_err});
    end
    edges_to_release(n);
    checks++;
    if (n != HOLD + 1) begin
      failures++;
      $display("[TB] FAIL good_load_release: core_reset fell after %0d cycles, required %0d", n, HOLD + 1);
    end
  endtask

  task automatic test_bad_loads();
    int n;
    bit exp_ok;
    // Short image.
    start_dl(1'b0);
    for (int a = 0; a < ROM - 1; a++) send_write(a, 8'($urandom));
    end_dl(1'b0);
    exp_ok = (m_cnt == ROM) && !m_ovf;
    checks++;
    if (!pulses_match()) begin
      failures++;
      $display("[TB] FAIL short_pulses: %0d pulses observed, %0d required", obs_q.size(), exp_q.size());
    end
    checks++;
    if ({load_ok, load_err} !== {exp_ok, !exp_ok}) begin
      failures++;
      $display("[TB] FAIL short_flags: ok/err=%b required %b", {load_ok, load_err}, {exp_ok, !exp_ok});
    end
    edges_to_release(n);
    checks++;
    if (core_reset !== 1'b1) begin
      failures++;
      $display("[TB] FAIL short_core_reset: core_reset=%b after %0d cycles, required 1", core_reset, n);
    end
    // Long image including one out-of-range address.
    start_dl(1'b0);
    for (int a = 0; a <= ROM; a++) send_write(a, 8'($urandom));
    end_dl(1'b0);
    exp_ok = (m_cnt == ROM) && !m_ovf;
    checks++;
    if (!pulses_match() || exp_q.size() != ROM) begin
      failures++;
      $display("[TB] FAIL long_pulses: %0d pulses observed, %0d required", obs_q.size(), ROM);
    end
    checks++;
    if ({load_ok, load_err} !== {exp_ok, !exp_ok}) begin
      failures++;
      $display("[TB] FAIL long_flags: ok/err=%b required %b", {load_ok, load_err}, {exp_ok, !exp_ok});
    end
    // Random in-range image with writes on the rise and fall cycles, which must not count.
    start_dl(1'b1);
    for (int i = 0; i < ROM; i++) send_write($urandom_range(0, ROM - 1), 8'($urandom));
    end_dl(1'b1);
    exp_ok = (m_cnt == ROM) && !m_ovf;
    checks++;
    if (!pulses_match()) begin
      failures++;
      $display("[TB] FAIL random_pulses: %0d pulses observed, %0d required", obs_q.size(), exp_q.size());
    end
    checks++;
    if ({load_ok, load_err} !== {exp_ok, !exp_ok}) begin
      failures++;
      $display("[TB] FAIL random_flags: ok/err=%b required %b", {load_ok, load_err}, {exp_ok, !exp_ok});
    end
    edges_to_release(n);
    checks++;
    if (n != HOLD + 1) begin
      failures++;
      $display("[TB] FAIL random_release: core_reset fell after %0d cycles, required %0d", n, HOLD + 1);
    end
  endtask

  task automatic test_user_reset();
    int len;
    int fall;
    logic first;
    for (int k = 0; k < 2; k++) begin
      len = (k == 0) ? 3 : int'($urandom_range(1, 5));
      checks++;
      if (core_reset !== 1'b0) begin
        failures++;
        $display("[TB] FAIL user_reset_pre: core_reset=%b required 0", core_reset);
      end
      rst_req = 1'b1;
      fall = 0;
      first = 1'bx;
      for (int i = 1; i <= 40; i++) begin
        tick();
        if (i == len) rst_req = 1'b0;
        if (i == 1) first = core_reset;
        if (core_reset === 1'b0) begin
          fall = i;
          break;
        end
      end
      rst_req = 1'b0;
      checks++;
      if (first !== 1'b1) begin
        failures++;
        $display("[TB] FAIL user_reset_rise: core_reset=%b one cycle after request, required 1", first);
      end
      checks++;
      if (fall != len + HOLD + 1) begin
        failures++;
        $display("[TB] FAIL user_reset_len: core_reset fell at cycle %0d, required %0d (req %0d cycles)",
                 fall, len + HOLD + 1, len);
      end
    end
  endtask

  task automatic test_dl_beats_rst();
    int n;
    rst_req = 1'b1;
    start_dl(1'b0);
    rst_req = 1'b0;
    for (int i = 0; i < ROM; i++) send_write(i, 8'($urandom));
    end_dl(1'b0);
    checks++;
    if (!pulses_match()) begin
      failures++;
      $display("[TB] FAIL dl_vs_rst_pulses: %0d pulses observed, %0d required", obs_q.size(), exp_q.size());
    end
    checks++;
    if ({load_ok, load_err} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL dl_vs_rst_flags: ok/err=%b required 10", {load_ok, load_err});
    end
    edges_to_release(n);
    checks++;
    if (n != HOLD + 1) begin
      failures++;
      $display("[TB] FAIL dl_vs_rst_release: core_reset fell after %0d cycles, required %0d", n, HOLD + 1);
    end
  endtask

  task automatic test_async_abort();
    logic [30:0] rst_vec;
    int bad = 0;
    int n;
    start_dl(1'b0);
    for (int a = 0; a < 5; a++) send_write(a, 8'($urandom));
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr = 1'b0;
    #1;
    rst_vec = {dn_addr, dn_data, dn_wr, dn_region, core_reset, load_ok, load_err};
    checks++;
    if (rst_vec !== {17'd0, 8'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("[TB] FAIL abort_values: got %h expected %h", rst_vec,
               {17'd0, 8'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0});
    end
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (core_reset !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("[TB] FAIL abort_stays_reset: %0d cycles with core_reset low, required 0", bad);
    end
    start_dl(1'b0);
    for (int a = 0; a < ROM; a++) send_write(a, 8'($urandom));
    end_dl(1'b0);
    checks++;
    if (!pulses_match() || {load_ok, load_err} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL abort_reload: pulses %0d/%0d ok/err=%b required 10",
               obs_q.size(), exp_q.size(), {load_ok, load_err});
    end
    edges_to_release(n);
    checks++;
    if (n != HOLD + 1) begin
      failures++;
      $display("[TB] FAIL abort_release: core_reset fell after %0d cycles, required %0d", n, HOLD + 1);
    end
  endtask

  initial begin
    test_reset();
    test_boot_idle();
    test_good_load();
    test_bad_loads();
    test_user_reset();
    test_dl_beats_rst();
    test_async_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
